// File: rtl/alarm_controller.sv
// Alarm clock controller: stores a BCD HH:MM alarm time and sequences
// IDLE / ARMED / RINGING / SNOOZE with minute-based snooze and ring timeout.
module alarm_controller #(
  parameter int SNOOZE_MINUTES       = 9,
  parameter int RING_TIMEOUT_MINUTES = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        one_minute,
  input  logic [15:0] current_time,
  input  logic        set_alarm,
  input  logic [15:0] new_alarm_time,
  input  logic        alarm_enable,
  input  logic        snooze,
  input  logic        stop,
  output logic [15:0] alarm_time,
  output logic        alarm_on,
  output logic        snooze_active,
  output logic        set_error
);

  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

  localparam logic [5:0] SNOOZE_LIM = 6'(SNOOZE_MINUTES);
  localparam logic [5:0] RING_LIM   = 6'(RING_TIMEOUT_MINUTES);

  state_t     state;
  state_t     state_nxt;
  logic       match_prev;
  logic       match_prev_nxt;
  logic [5:0] min_cnt;
  logic [5:0] min_cnt_nxt;
  logic [5:0] cnt_inc;
  logic       match;
  logic       match_rise;
  logic       set_ok;
  logic       in_alert;

  function automatic logic time_valid(input logic [15:0] t);
    logic hr_ok;
    logic min_ok;
    hr_ok  = (t[15:12] <= 4'd2) && (t[11:8] <= 4'd9) &&
             !((t[15:12] == 4'd2) && (t[11:8] > 4'd3));
    min_ok = (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    return hr_ok && min_ok;
  endfunction

  // Saturating increment keeps the minute counter from wrapping.
  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'h3f) ? v : v + 6'd1;
  endfunction

  always_comb begin
    match      = (current_time == alarm_time);
    match_rise = match & ~match_prev;
    set_ok     = set_alarm & time_valid(new_alarm_time);
    in_alert   = (state == RINGING) || (state == SNOOZE);
    cnt_inc    = sat_inc(min_cnt);

    state_nxt = state;
    case (state)
      IDLE:    if (alarm_enable) state_nxt = ARMED;
      ARMED:   if (match_rise) state_nxt = RINGING;
      RINGING: begin
        if (stop)                                     state_nxt = ARMED;
        else if (snooze)                              state_nxt = SNOOZE;
        else if (one_minute && (cnt_inc == RING_LIM)) state_nxt = ARMED;
      end
      SNOOZE: begin
        if (stop)                                       state_nxt = ARMED;
        else if (one_minute && (cnt_inc == SNOOZE_LIM)) state_nxt = RINGING;
      end
      default: state_nxt = IDLE;
    endcase
    if (set_ok && in_alert) state_nxt = ARMED;
    if (!alarm_enable)      state_nxt = IDLE;

    // A new time loaded while alerting must wait for a fresh match edge.
    match_prev_nxt = (set_ok && in_alert) ? 1'b1 : match;

    min_cnt_nxt = min_cnt;
    if ((state_nxt != state) && ((state_nxt == RINGING) || (state_nxt == SNOOZE)))
      min_cnt_nxt = 6'd0;
    else if (one_minute && in_alert)
      min_cnt_nxt = cnt_inc;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      alarm_time    <= 16'h0000;
      match_prev    <= 1'b1;
      min_cnt       <= 6'd0;
      alarm_on      <= 1'b0;
      snooze_active <= 1'b0;
      set_error     <= 1'b0;
    end else begin
      state         <= state_nxt;
      match_prev    <= match_prev_nxt;
      min_cnt       <= min_cnt_nxt;
      alarm_on      <= (state_nxt == RINGING);
      snooze_active <= (state_nxt == SNOOZE);
      set_error     <= set_alarm & ~set_ok;
      if (set_ok) alarm_time <= new_alarm_time;
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Table-driven bench for alarm_controller; expected outputs queued at drive
// time and checked one cycle later.
module tb_alarm_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        one_minute;
  logic [15:0] current_time;
  logic        set_alarm;
  logic [15:0] new_alarm_time;
  logic        alarm_enable;
  logic        snooze;
  logic        stop;
  logic [15:0] alarm_time;
  logic        alarm_on;
  logic        snooze_active;
  logic        set_error;

  alarm_controller #(.SNOOZE_MINUTES(9), .RING_TIMEOUT_MINUTES(30)) dut (
    .clock(clock), .reset(reset), .one_minute(one_minute),
    .current_time(current_time), .set_alarm(set_alarm),
    .new_alarm_time(new_alarm_time), .alarm_enable(alarm_enable),
    .snooze(snooze), .stop(stop), .alarm_time(alarm_time),
    .alarm_on(alarm_on), .snooze_active(snooze_active), .set_error(set_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sa;
    logic [15:0] nat;
    logic        en;
    logic [15:0] ct;
    logic        snz;
    logic        stp;
    logic        om;
    logic [18:0] exp;  // {alarm_on, snooze_active, set_error, alarm_time}
    string       name;
  } vec_t;

  typedef struct {
    logic [18:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic sa, input logic [15:0] nat,
                              input logic en, input logic [15:0] ct,
                              input logic snz, input logic stp, input logic om,
                              input logic on, input logic sact, input logic err,
                              input logic [15:0] at, input string name);
    vec_t v;
    v.sa = sa; v.nat = nat; v.en = en; v.ct = ct;
    v.snz = snz; v.stp = stp; v.om = om;
    v.exp = {on, sact, err, at};
    v.name = name;
    return v;
  endfunction

  task automatic check_out();
    exp_t        e;
    logic [18:0] got;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got no expectation, required one");
      return;
    end
    e   = q.pop_front();
    got = {alarm_on, snooze_active, set_error, alarm_time};
    n_vec++;
    if (got !== e.exp) begin
      n_bad++;
      $display("FAIL %s: got on=%b snz=%b err=%b at=%h, required on=%b snz=%b err=%b at=%h",
               e.name, got[18], got[17], got[16], got[15:0],
               e.exp[18], e.exp[17], e.exp[16], e.exp[15:0]);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clock);
    set_alarm      = v.sa;
    new_alarm_time = v.nat;
    alarm_enable   = v.en;
    current_time   = v.ct;
    snooze         = v.snz;
    stop           = v.stp;
    one_minute     = v.om;
    q.push_back('{exp: v.exp, name: v.name});
    @(posedge clock);
    #1;
    check_out();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; one_minute = 1'b0; current_time = 16'h0000;
    set_alarm = 1'b0; new_alarm_time = 16'h0000; alarm_enable = 1'b0;
    snooze = 1'b0; stop = 1'b0;

    tbl.push_back(mk(1, 16'h0630, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0630, "load_0630"));
    tbl.push_back(mk(1, 16'h2460, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0630, "bad_2460"));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0630, "err_one_cycle"));
    tbl.push_back(mk(1, 16'h1A00, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0630, "bad_1A00"));
    tbl.push_back(mk(1, 16'h3000, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0630, "bad_hr_tens"));
    tbl.push_back(mk(1, 16'h0575, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0630, "bad_min_tens"));
    tbl.push_back(mk(1, 16'h2359, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h2359, "load_2359"));
    tbl.push_back(mk(1, 16'h0630, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0630, "reload_0630"));
    tbl.push_back(mk(0, 16'h0000, 1, 16'h0629, 0, 0, 0, 0, 0, 0, 16'h0630, "armed_no_match"));
    tbl.push_back(mk(0, 16'h0000, 1, 16'h0630, 0, 0, 0, 1, 0, 0, 16'h0630, "ring_on_match"));
    tbl.push_back(mk(0, 16'h0000, 1, 16'h0630, 0, 0, 0, 1, 0, 0, 16'h0630, "still_ringing"));
    tbl.push_back(mk(0, 16'h0000, 1, 16'h0630, 0, 1, 0, 0, 0, 0, 16'h0630, "stop"));
    tbl.push_back(mk(0, 16'h0000, 1, 16'h0630, 0, 0, 0, 0, 0, 0, 16'h0630, "no_rering_same_min"));
    tbl.push_back(mk(0, 16'h0000, 1, 16'h0631, 0, 0, 0, 0, 0, 0, 16'h0630, "leave_match"));
    tbl.push_back(mk(0, 16'h0000, 1, 16'h0630, 0, 0, 0, 1, 0, 0, 16'h0630, "rering_next_match"));
    tbl.push_back(mk(0, 16'h0000, 1, 16'h0630, 1, 0, 0, 0, 1, 0, 16'h0630, "snooze_enter"));
    tbl.push_back(mk(0, 16'h0000, 1, 16'h0630, 1, 0, 0, 0, 1, 0, 16'h0630, "snooze_ignored"));

    #12;
    q.push_back('{exp: {1'b0, 1'b0, 1'b0, 16'h0000}, name: "reset_state"});
    check_out();
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Snooze period: ninth minute strobe re-rings.
    for (int i = 1; i <= 9; i++) begin
      apply(mk(0, 0, 1, 16'h0630, 0, 0, 1, (i == 9), (i != 9), 0, 16'h0630, "snooze_minute"));
      apply(mk(0, 0, 1, 16'h0630, 0, 0, 0, (i == 9), (i != 9), 0, 16'h0630, "snooze_gap"));
    end
    // Ring timeout after thirty strobes, with the time still matching.
    for (int i = 1; i <= 30; i++) begin
      apply(mk(0, 0, 1, 16'h0630, 0, 0, 1, (i != 30), 0, 0, 16'h0630, "timeout_minute"));
      apply(mk(0, 0, 1, 16'h0630, 0, 0, 0, (i != 30), 0, 0, 16'h0630, "timeout_gap"));
    end
    apply(mk(0, 0, 1, 16'h0631, 0, 0, 0, 0, 0, 0, 16'h0630, "after_timeout_leave"));
    apply(mk(0, 0, 1, 16'h0630, 0, 0, 0, 1, 0, 0, 16'h0630, "armed_after_timeout"));

    apply(mk(0, 0, 1, 16'h0630, 1, 1, 0, 0, 0, 0, 16'h0630, "snooze_stop_same_cycle"));
    apply(mk(0, 0, 1, 16'h0630, 0, 0, 0, 0, 0, 0, 16'h0630, "no_snooze_after_stop"));

    apply(mk(0, 0, 1, 16'h0631, 0, 0, 0, 0, 0, 0, 16'h0630, "leave_2"));
    apply(mk(0, 0, 1, 16'h0630, 0, 0, 0, 1, 0, 0, 16'h0630, "ring_2"));
    apply(mk(0, 0, 1, 16'h0630, 1, 0, 0, 0, 1, 0, 16'h0630, "snooze_2"));
    apply(mk(1, 16'h0630, 1, 16'h0630, 0, 0, 0, 0, 0, 0, 16'h0630, "set_in_snooze_arms"));
    apply(mk(0, 0, 1, 16'h0630, 0, 0, 0, 0, 0, 0, 16'h0630, "no_ring_same_time"));

    apply(mk(0, 0, 1, 16'h0631, 0, 0, 0, 0, 0, 0, 16'h0630, "leave_3"));
    apply(mk(0, 0, 1, 16'h0630, 0, 0, 0, 1, 0, 0, 16'h0630, "ring_3"));
    apply(mk(0, 0, 1, 16'h0630, 1, 0, 0, 0, 1, 0, 16'h0630, "snooze_3"));
    apply(mk(0, 0, 0, 16'h0630, 0, 0, 0, 0, 0, 0, 16'h0630, "disable_in_snooze"));
    apply(mk(0, 0, 0, 16'h0631, 0, 0, 0, 0, 0, 0, 16'h0630, "idle_leave"));
    apply(mk(0, 0, 0, 16'h0630, 0, 0, 0, 0, 0, 0, 16'h0630, "idle_ignores_match"));
    apply(mk(0, 0, 1, 16'h0630, 0, 0, 0, 0, 0, 0, 16'h0630, "enable_mid_match"));
    apply(mk(0, 0, 1, 16'h0630, 0, 0, 0, 0, 0, 0, 16'h0630, "enable_mid_match_hold"));
    apply(mk(0, 0, 1, 16'h0631, 0, 0, 0, 0, 0, 0, 16'h0630, "leave_4"));
    apply(mk(0, 0, 1, 16'h0630, 0, 0, 0, 1, 0, 0, 16'h0630, "ring_after_enable"));

    // Asynchronous reset while ringing.
    @(negedge clock);
    current_time = 16'h0000;
    alarm_enable = 1'b1;
    reset = 1'b1;
    #1;
    q.push_back('{exp: {1'b0, 1'b0, 1'b0, 16'h0000}, name: "reset_silences"});
    check_out();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      apply(mk(0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, "no_ring_after_reset"));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
